// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: shared RV64M funct3 encodings, datapath width and FSM state encodings
package mdu_iter_pkg;
  localparam int MDU_XLEN = 64;
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;
  localparam logic [1:0] MDU_IDLE   = 2'd0;
  localparam logic [1:0] MDU_CALC   = 2'd1;
  localparam logic [1:0] MDU_FIX    = 2'd2;
  localparam logic [1:0] MDU_DONE   = 2'd3;
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: combinational restoring step; in rem_i (shifted N+1-bit partial remainder), div_i; out rem_o, q_o
module mdu_div_step
  import mdu_iter_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);
  logic [XLEN:0] w_diff;
  always_comb begin
    w_diff = rem_i - {1'b0, div_i};
    q_o    = ~w_diff[XLEN];
    rem_o  = q_o ? w_diff[XLEN-1:0] : rem_i[XLEN-1:0];
  end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M mul/div; in clk, rst_n, DivEn, DivSel, Div32, src1_i, src2_i, flush_i; out ready_o, busy_o, done_o, result_o
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            DivEn,
  input  logic [2:0]      DivSel,
  input  logic            Div32,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  logic [1:0]        r_state, w_nxt;
  logic [2:0]        r_sel;
  logic              r_w, r_n1, r_n2;
  logic [6:0]        r_cnt;
  logic [2*XLEN-1:0] r_a, r_p;
  logic [XLEN-1:0]   r_b, r_res;
  logic              w_sx, w_s1, w_s2, w_dz, w_q;
  logic [XLEN-1:0]   w_x1, w_x2, w_m1, w_m2, w_rem, w_fix;
  logic [2*XLEN-1:0] w_prod;
  // r_p holds the product for multiplies, or {remainder, quotient} for divides
  mdu_div_step #(.XLEN(XLEN)) u_step (
    .rem_i({r_p[2*XLEN-1:XLEN], r_b[XLEN-1]}),
    .div_i(r_a[XLEN-1:0]),
    .rem_o(w_rem),
    .q_o  (w_q)
  );
  always_comb begin
    w_sx   = !(DivSel inside {MDU_DIVU, MDU_REMU});
    w_x1   = Div32 ? {{32{w_sx & src1_i[31]}}, src1_i[31:0]} : src1_i;
    w_x2   = Div32 ? {{32{w_sx & src2_i[31]}}, src2_i[31:0]} : src2_i;
    w_s1   = DivSel inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    w_s2   = DivSel inside {MDU_MULH, MDU_DIV, MDU_REM};
    w_m1   = (w_s1 & w_x1[XLEN-1]) ? -w_x1 : w_x1;
    w_m2   = (w_s2 & w_x2[XLEN-1]) ? -w_x2 : w_x2;
    w_dz   = DivSel[2] & ~|w_x2;
    w_prod = (r_n1 ^ r_n2) ? -r_p : r_p;
    w_fix  = r_sel == MDU_MUL ? w_prod[XLEN-1:0] :
             r_sel inside {MDU_MULH, MDU_MULHSU, MDU_MULHU} ? w_prod[2*XLEN-1:XLEN] :
             r_sel[1] ? (r_n1 ? -r_p[2*XLEN-1:XLEN] : r_p[2*XLEN-1:XLEN]) :
             ((r_n1 ^ r_n2) ? -r_p[XLEN-1:0] : r_p[XLEN-1:0]);
    w_nxt  = flush_i ? MDU_IDLE :
             r_state == MDU_IDLE ? (DivEn ? (w_dz ? MDU_FIX : MDU_CALC) : MDU_IDLE) :
             r_state == MDU_CALC ? (r_cnt == 7'd1 ? MDU_FIX : MDU_CALC) :
             r_state == MDU_FIX ? MDU_DONE : MDU_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MDU_IDLE;
      r_sel   <= '0;
      r_w     <= 1'b0;
      r_n1    <= 1'b0;
      r_n2    <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_nxt;
      if (!flush_i) begin
        if (r_state == MDU_IDLE && DivEn) begin
          r_sel <= DivSel;
          r_w   <= Div32;
          r_cnt <= Div32 ? 7'd32 : 7'd64;
          // zero divisor: preload all-ones quotient and raw dividend as remainder, no sign fix
          r_n1  <= ~w_dz & w_s1 & w_x1[XLEN-1];
          r_n2  <= ~w_dz & w_s2 & w_x2[XLEN-1];
          r_a   <= {{XLEN{1'b0}}, DivSel[2] ? w_m2 : w_m1};
          // W divides start with the dividend MSB at the top so bits shift out MSB-first
          r_b   <= DivSel[2] ? (Div32 ? {w_m1[31:0], 32'b0} : w_m1) : w_m2;
          r_p   <= w_dz ? {w_x1, {XLEN{1'b1}}} : '0;
        end else if (r_state == MDU_CALC) begin
          r_cnt <= r_cnt - 7'd1;
          if (r_sel[2]) begin
            r_p <= {w_rem, r_p[XLEN-2:0], w_q};
            r_b <= r_b << 1;
          end else begin
            if (r_b[0]) r_p <= r_p + r_a;
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
          end
        end else if (r_state == MDU_FIX) begin
          r_res <= r_w ? {{32{w_fix[31]}}, w_fix[31:0]} : w_fix;
        end
      end
    end
  end
  assign ready_o  = r_state == MDU_IDLE;
  assign busy_o   = r_state == MDU_CALC || r_state == MDU_FIX;
  assign done_o   = r_state == MDU_DONE;
  assign result_o = r_res;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized self-checking bench for mdu_iter against an arithmetic reference model
module tb_mdu_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        DivEn = 1'b0;
  logic [2:0]  DivSel = 3'd0;
  logic        Div32 = 1'b0;
  logic [63:0] src1_i = '0;
  logic [63:0] src2_i = '0;
  logic        flush_i = 1'b0;
  logic        ready_o, busy_o, done_o;
  logic [63:0] result_o;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          lat = 0;
  bit          pending = 0;
  logic [63:0] exp_r = '0;
  logic [63:0] last_r = '0;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  mdu_iter #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .DivEn(DivEn), .DivSel(DivSel), .Div32(Div32),
    .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [63:0] ref_f(input logic [2:0] s, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, sp;
    logic [127:0] up;
    logic signed [63:0] a64, b64;
    logic signed [31:0] a32, b32;
    logic [31:0] r32;
    logic [63:0] r;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    a64 = a;
    b64 = b;
    a32 = a[31:0];
    b32 = b[31:0];
    r = '0;
    r32 = '0;
    if (!w) begin
      case (s)
        3'd0: begin up = {64'b0, a} * {64'b0, b}; r = up[63:0]; end
        3'd1: begin sp = sa * sb; r = sp[127:64]; end
        3'd2: begin sp = sa * $signed({64'b0, b}); r = sp[127:64]; end
        3'd3: begin up = {64'b0, a} * {64'b0, b}; r = up[127:64]; end
        3'd4: if (b == 0) r = ONES; else if (a == MIN && b == ONES) r = a; else r = a64 / b64;
        3'd5: if (b == 0) r = ONES; else r = a / b;
        3'd6: if (b == 0) r = a; else if (a == MIN && b == ONES) r = 0; else r = a64 % b64;
        default: if (b == 0) r = a; else r = a % b;
      endcase
    end else begin
      case (s)
        3'd0: r32 = a[31:0] * b[31:0];
        3'd4: if (b32 == 0) r32 = '1; else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) r32 = a[31:0]; else r32 = a32 / b32;
        3'd5: if (b32 == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
        3'd6: if (b32 == 0) r32 = a[31:0]; else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) r32 = 0; else r32 = a32 % b32;
        3'd7: if (b32 == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  function automatic int lat_f(input logic [2:0] s, input logic w, input logic [63:0] b);
    return (s[2] && (w ? b[31:0] == 0 : b == 0)) ? 2 : (w ? 34 : 66);
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'd1;
      2: return ONES;
      3: return MIN;
      4: return 64'($urandom_range(0, 20)) * (($urandom_range(0, 1) == 1) ? ONES : 64'd1);
      5: return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // per-cycle compare against an "accepted at t0, done at t0+lat" view of the unit
  always @(negedge clk) begin
    int k;
    if (!rst_n) begin
      pending = 0;
      last_r = '0;
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_result", result_o, 64'd0);
    end else if (!pending) begin
      chk("idle_ready", 64'(ready_o), 64'd1);
      chk("idle_busy", 64'(busy_o), 64'd0);
      chk("idle_done", 64'(done_o), 64'd0);
      chk("idle_hold", result_o, last_r);
      if (DivEn && !flush_i) begin
        pending = 1;
        t0 = cyc;
        lat = lat_f(DivSel, Div32, src2_i);
        exp_r = ref_f(DivSel, Div32, src1_i, src2_i);
      end
    end else begin
      k = cyc - t0;
      chk("ready", 64'(ready_o), 64'd0);
      chk("busy", 64'(busy_o), 64'(k < lat));
      chk("done", 64'(done_o), 64'(k == lat));
      chk("result", result_o, k == lat ? exp_r : last_r);
      if (k == lat) begin
        pending = 0;
        last_r = exp_r;
      end else if (flush_i) pending = 0;
    end
  end

  // ev: 1 flush, 2 reset, 3 stray DivEn, applied in cycle ev_k after accept
  task automatic op(input logic [2:0] s, input logic w, input logic [63:0] a, input logic [63:0] b,
                    input int ev_k = -1, input int ev = 0);
    @(posedge clk) #2;
    DivSel = s; Div32 = w; src1_i = a; src2_i = b; DivEn = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk) #2;
      DivEn = 1'b0; flush_i = 1'b0; rst_n = 1'b1;
      src1_i = {$urandom, $urandom}; src2_i = {$urandom, $urandom};
      DivSel = 3'($urandom); Div32 = 1'($urandom);
      if (!pending) break;
      if (k == ev_k) begin
        if (ev == 1) flush_i = 1'b1;
        if (ev == 2) rst_n = 1'b0;
        if (ev == 3) DivEn = 1'b1;
      end
    end
    chk("timeout", 64'(pending), 64'd0);
  endtask

  task automatic pin(input string nm, input logic [2:0] s, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] lit, input int lit_lat);
    chk({nm, "_model"}, ref_f(s, w, a, b), lit);
    chk({nm, "_lat"}, 64'(lat_f(s, w, b)), 64'(lit_lat));
    op(s, w, a, b);
    chk({nm, "_dut"}, result_o, lit);
  endtask

  initial begin
    logic [2:0] s;
    logic w;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    pin("mul", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 66);
    pin("mulh", 3'd1, 1'b0, ONES, ONES, 64'd0, 66);
    pin("mulhu", 3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    pin("mulhsu", 3'd2, 1'b0, ONES, 64'd2, ONES, 66);
    pin("div", 3'd4, 1'b0, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    pin("rem", 3'd6, 1'b0, -64'd7, 64'd2, ONES, 66);
    pin("divu", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66);
    pin("remu", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66);
    pin("divu0", 3'd5, 1'b0, 64'd5, 64'd0, ONES, 2);
    pin("remu0", 3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 2);
    pin("div0", 3'd4, 1'b0, -64'd5, 64'd0, ONES, 2);
    pin("divovf", 3'd4, 1'b0, MIN, ONES, MIN, 66);
    pin("removf", 3'd6, 1'b0, MIN, ONES, 64'd0, 66);
    pin("divwovf", 3'd4, 1'b1, 64'h8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 34);
    pin("mulw", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    pin("divuw", 3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, ONES, 34);
    op(3'd4, 1'b0, 64'd1000, 64'd3, 10, 1);
    chk("flush_hold", result_o, ONES);
    pin("after_flush", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66);
    op(3'd4, 1'b0, 64'd77, 64'd5, 5, 3);
    op(3'd0, 1'b0, 64'd123, 64'd456, 20, 2);
    chk("rst_result_mid", result_o, 64'd0);
    pin("after_rst", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 66);
    for (int i = 0; i < 150; i++) begin
      s = 3'($urandom);
      w = 1'($urandom);
      if (w && s inside {3'd1, 3'd2, 3'd3}) s = 3'd0;
      if ($urandom_range(0, 19) == 0) op(s, w, rnd64(), rnd64(), $urandom_range(1, 40), 1);
      else op(s, w, rnd64(), rnd64());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
